// File: rtl/conv_core.sv
// 5x5 valid convolution engine over 8-lane 128-bit image/weight RAM words.
// One output pixel every 29 cycles: 25 read cycles, 3 pipeline drain cycles, 1 output cycle.
module conv_core (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                convStart,
  input  logic [5:0]          W,
  input  logic [5:0]          H,
  input  logic [4:0]          C,
  output logic                ramImage_en_r,
  output logic [9:0]          ramImage_addrR,
  input  logic [127:0]        ramImage_dout,
  output logic                ramWeight_en_r,
  output logic [4:0]          ramWeight_addrR,
  input  logic [127:0]        ramWeight_dout,
  output logic                conv_valid,
  output logic signed [39:0]  conv_data,
  output logic [5:0]          conv_x,
  output logic [5:0]          conv_y,
  output logic                convFinish
);

  localparam int unsigned DIM_W   = 6;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned WADDR_W = 5;
  localparam int unsigned LANES   = 8;
  localparam int unsigned LANE_W  = 16;
  localparam int unsigned MUL_W   = 32;
  localparam int unsigned PROD_W  = 35;
  localparam int unsigned ACC_W   = 40;
  localparam int unsigned KCNT_W  = 5;
  localparam int unsigned KDIM_W  = 3;
  localparam int unsigned CALC_W  = 16;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, OUT, DONE} state_t;

  state_t              state, state_n;
  logic [KCNT_W-1:0]   k, k_n;
  logic [KDIM_W-1:0]   kx, kx_n, ky, ky_n;
  logic [DIM_W-1:0]    ox, ox_n, oy, oy_n;
  logic [DIM_W-1:0]    w_l, w_n, h_l, h_n;
  logic                issue_n, valid_n, finish_n, is_last;
  logic [ADDR_W-1:0]   img_addr_n;

  logic                rd_vld, psum_vld;
  logic signed [PROD_W-1:0] psum, dot;
  logic signed [ACC_W-1:0]  acc;
  logic signed [LANE_W-1:0] lane_a, lane_b;
  logic signed [MUL_W-1:0]  prod;

  // Channel count is informational only.
  logic unused_c;
  assign unused_c = ^C;

  assign is_last = (ox == w_l - DIM_W'(5)) && (oy == h_l - DIM_W'(5));

  // State register and sequencing counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      kx    <= '0;
      ky    <= '0;
      ox    <= '0;
      oy    <= '0;
      w_l   <= '0;
      h_l   <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
      kx    <= kx_n;
      ky    <= ky_n;
      ox    <= ox_n;
      oy    <= oy_n;
      w_l   <= w_n;
      h_l   <= h_n;
    end
  end

  // Next-state logic; RAM request and strobe values are computed one cycle ahead.
  always_comb begin
    state_n  = state;
    k_n      = k;
    kx_n     = kx;
    ky_n     = ky;
    ox_n     = ox;
    oy_n     = oy;
    w_n      = w_l;
    h_n      = h_l;
    issue_n  = 1'b0;
    valid_n  = 1'b0;
    finish_n = 1'b0;
    case (state)
      IDLE: begin
        if (convStart) begin
          w_n  = W;
          h_n  = H;
          k_n  = '0;
          kx_n = '0;
          ky_n = '0;
          ox_n = '0;
          oy_n = '0;
          if (W < DIM_W'(5) || H < DIM_W'(5)) begin
            state_n  = DONE;
            finish_n = 1'b1;
          end else begin
            state_n = RUN;
            issue_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (k == KCNT_W'(24)) begin
          state_n = DRAIN;
          k_n     = '0;
        end else begin
          issue_n = 1'b1;
          k_n     = k + KCNT_W'(1);
          if (kx == KDIM_W'(4)) begin
            kx_n = '0;
            ky_n = ky + KDIM_W'(1);
          end else begin
            kx_n = kx + KDIM_W'(1);
          end
        end
      end
      DRAIN: begin
        if (k == KCNT_W'(2)) begin
          state_n = OUT;
          k_n     = '0;
          valid_n = 1'b1;
        end else begin
          k_n = k + KCNT_W'(1);
        end
      end
      OUT: begin
        k_n  = '0;
        kx_n = '0;
        ky_n = '0;
        if (is_last) begin
          state_n  = DONE;
          finish_n = 1'b1;
        end else begin
          state_n = RUN;
          issue_n = 1'b1;
          if (ox == w_l - DIM_W'(5)) begin
            ox_n = '0;
            oy_n = oy + DIM_W'(1);
          end else begin
            ox_n = ox + DIM_W'(1);
          end
        end
      end
      DONE: begin
        if (!convStart) state_n = IDLE;
        else            finish_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    img_addr_n = ADDR_W'((CALC_W'(oy_n) + CALC_W'(ky_n)) * CALC_W'(w_n)
                         + CALC_W'(ox_n) + CALC_W'(kx_n));
  end

  // Eight-lane signed dot product of the current RAM words.
  always_comb begin
    dot    = '0;
    lane_a = '0;
    lane_b = '0;
    prod   = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_a = ramImage_dout[i*LANE_W +: LANE_W];
      lane_b = ramWeight_dout[i*LANE_W +: LANE_W];
      prod   = MUL_W'(lane_a) * MUL_W'(lane_b);
      dot    = dot + PROD_W'(prod);
    end
  end

  // RAM requests, product/accumulate pipeline and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramImage_en_r   <= 1'b0;
      ramImage_addrR  <= '0;
      ramWeight_en_r  <= 1'b0;
      ramWeight_addrR <= '0;
      rd_vld          <= 1'b0;
      psum_vld        <= 1'b0;
      psum            <= '0;
      acc             <= '0;
      conv_valid      <= 1'b0;
      conv_data       <= '0;
      conv_x          <= '0;
      conv_y          <= '0;
      convFinish      <= 1'b0;
    end else begin
      ramImage_en_r  <= issue_n;
      ramWeight_en_r <= issue_n;
      if (issue_n) begin
        ramImage_addrR  <= img_addr_n;
        ramWeight_addrR <= WADDR_W'(k_n);
      end
      rd_vld   <= ramImage_en_r;
      psum_vld <= rd_vld;
      if (rd_vld) psum <= dot;
      if (valid_n)       acc <= '0;
      else if (psum_vld) acc <= acc + ACC_W'(psum);
      conv_valid <= valid_n;
      if (valid_n) begin
        conv_data <= acc;
        conv_x    <= ox;
        conv_y    <= oy;
      end
      convFinish <= finish_n;
    end
  end

endmodule

// File: tb/tb_conv_core.sv
// Self-checking bench for conv_core: RAM models, a direct-formula convolution
// reference, a table of run cases and hand-written reset / early-release sequences.
module tb_conv_core;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               convStart = 1'b0;
  logic [5:0]         W = '0;
  logic [5:0]         H = '0;
  logic [4:0]         C = 5'd8;
  logic               ramImage_en_r;
  logic [9:0]         ramImage_addrR;
  logic [127:0]       ramImage_dout = '0;
  logic               ramWeight_en_r;
  logic [4:0]         ramWeight_addrR;
  logic [127:0]       ramWeight_dout = '0;
  logic               conv_valid;
  logic signed [39:0] conv_data;
  logic [5:0]         conv_x;
  logic [5:0]         conv_y;
  logic               convFinish;

  conv_core dut (
    .clk(clk), .rst_n(rst_n), .convStart(convStart), .W(W), .H(H), .C(C),
    .ramImage_en_r(ramImage_en_r), .ramImage_addrR(ramImage_addrR), .ramImage_dout(ramImage_dout),
    .ramWeight_en_r(ramWeight_en_r), .ramWeight_addrR(ramWeight_addrR), .ramWeight_dout(ramWeight_dout),
    .conv_valid(conv_valid), .conv_data(conv_data), .conv_x(conv_x), .conv_y(conv_y),
    .convFinish(convFinish)
  );

  always #5 clk = ~clk;

  logic [127:0] img_mem [1024];
  logic [127:0] wgt_mem [32];

  always @(posedge clk) begin
    if (ramImage_en_r)  ramImage_dout  <= img_mem[ramImage_addrR];
    if (ramWeight_en_r) ramWeight_dout <= wgt_mem[ramWeight_addrR];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: direct sum over the 5x5 window and 8 lanes.
  function automatic longint ref_conv(input int ox, input int oy, input int w);
    longint s = 0;
    logic [127:0] wi, ww;
    logic signed [15:0] a, b;
    for (int ky = 0; ky < 5; ky++)
      for (int kx = 0; kx < 5; kx++) begin
        wi = img_mem[((oy + ky) * w + ox + kx) % 1024];
        ww = wgt_mem[ky * 5 + kx];
        for (int l = 0; l < 8; l++) begin
          a = wi[16*l +: 16];
          b = ww[16*l +: 16];
          s += longint'(a) * longint'(b);
        end
      end
    return s;
  endfunction

  longint exp_d[$];
  int     exp_x[$];
  int     exp_y[$];

  task automatic build_expected(input int w, input int h);
    exp_d.delete(); exp_x.delete(); exp_y.delete();
    if (w >= 5 && h >= 5)
      for (int oy = 0; oy <= h - 5; oy++)
        for (int ox = 0; ox <= w - 5; ox++) begin
          exp_d.push_back(ref_conv(ox, oy, w));
          exp_x.push_back(ox);
          exp_y.push_back(oy);
        end
  endtask

  task automatic fill(input int pat);
    for (int n = 0; n < 1024; n++)
      case (pat)
        0:       img_mem[n] = 128'(n);
        1:       img_mem[n] = {128{1'b1}};
        default: img_mem[n] = {$urandom, $urandom, $urandom, $urandom};
      endcase
    for (int k = 0; k < 32; k++)
      case (pat)
        0:       wgt_mem[k] = 128'(k);
        1:       wgt_mem[k] = {8{16'h0002}};
        default: wgt_mem[k] = {$urandom, $urandom, $urandom, $urandom};
      endcase
  endtask

  // Output monitor: strobe checking against the reference queue plus run statistics.
  bit     mon_en = 1'b0;
  int     cyc, got, reads, first_lat, fin_lat;
  bit     hold_bad, en_bad;
  longint got_data [64];
  logic signed [39:0] last_d;
  logic [5:0] last_x, last_y;

  task automatic reset_mon();
    cyc = 0; got = 0; reads = 0; first_lat = -1; fin_lat = -1;
    hold_bad = 1'b0; en_bad = 1'b0;
    last_d = conv_data; last_x = conv_x; last_y = conv_y;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (ramImage_en_r) reads++;
      if (ramImage_en_r !== ramWeight_en_r) en_bad = 1'b1;
      if (convFinish === 1'b1 && fin_lat < 0) fin_lat = cyc;
      if (conv_valid === 1'b1) begin
        if (got == 0) first_lat = cyc;
        if (got < 64) got_data[got] = longint'(conv_data);
        if (exp_d.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_strobe: got strobe %0d with no expected pixel", got);
        end else begin
          chk("conv_data", conv_data, exp_d.pop_front());
          chk("conv_x", conv_x, exp_x.pop_front());
          chk("conv_y", conv_y, exp_y.pop_front());
        end
        got++;
      end else if (conv_data !== last_d || conv_x !== last_x || conv_y !== last_y) begin
        hold_bad = 1'b1;
      end
      last_d = conv_data; last_x = conv_x; last_y = conv_y;
    end
  end

  task automatic apply_reset(input int w, input int h);
    mon_en = 1'b0;
    rst_n = 1'b0; convStart = 1'b0;
    W = 6'(w); H = 6'(h);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start();
    @(negedge clk); #1;
    reset_mon();
    mon_en = 1'b1;
    convStart = 1'b1;
  endtask

  task automatic wait_finish(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (fin_lat >= 0) break;
    end
    chk("finish_seen", 64'(fin_lat >= 0), 64'd1);
  endtask

  typedef struct {
    int     w;
    int     h;
    int     pat;
    bit     chk_first;
    longint first_exp;
    int     count_exp;
  } vec_t;

  task automatic run_case(input vec_t v);
    fill(v.pat);
    build_expected(v.w, v.h);
    apply_reset(v.w, v.h);
    start();
    wait_finish(v.count_exp * 29 + 60);
    chk("finish_cycle", fin_lat, 29 * v.count_exp + 1);
    chk("strobes", got, v.count_exp);
    chk("ram_reads", reads, 25 * v.count_exp);
    if (v.count_exp > 0) chk("first_latency", first_lat, 29);
    if (v.chk_first) chk("first_value", got_data[0], v.first_exp);
    if (v.pat == 0 && v.w == 32 && v.h == 32) begin
      chk("value_1_0", got_data[1], 28150);
      chk("value_0_1", got_data[28], 37450);
    end
    chk("hold_outside_out", hold_bad, 0);
    chk("en_match", en_bad, 0);
    chk("leftover_expected", exp_d.size(), 0);
    repeat (3) @(negedge clk);
    #1;
    chk("finish_held", convFinish, 1);
    convStart = 1'b0;
    @(negedge clk); #1;
    chk("finish_drop", convFinish, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("idle_quiet", 64'(got + reads), 64'(v.count_exp + 25 * v.count_exp));
    mon_en = 1'b0;
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{w: 32, h: 32, pat: 0, chk_first: 1, first_exp: 27850, count_exp: 784};
    vecs[1] = '{w: 8,  h: 6,  pat: 1, chk_first: 1, first_exp: -400,  count_exp: 8};
    vecs[2] = '{w: 4,  h: 32, pat: 0, chk_first: 0, first_exp: 0,     count_exp: 0};
    vecs[3] = '{w: 32, h: 4,  pat: 0, chk_first: 0, first_exp: 0,     count_exp: 0};
    vecs[4] = '{w: 5,  h: 5,  pat: 2, chk_first: 0, first_exp: 0,     count_exp: 1};
    vecs[5] = '{w: 7,  h: 9,  pat: 2, chk_first: 0, first_exp: 0,     count_exp: 15};
    vecs[6] = '{w: 50, h: 21, pat: 2, chk_first: 0, first_exp: 0,     count_exp: 782};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_img_en", ramImage_en_r, 0);
    chk("rst_img_addr", ramImage_addrR, 0);
    chk("rst_wgt_en", ramWeight_en_r, 0);
    chk("rst_wgt_addr", ramWeight_addrR, 0);
    chk("rst_valid", conv_valid, 0);
    chk("rst_data", conv_data, 0);
    chk("rst_x", conv_x, 0);
    chk("rst_y", conv_y, 0);
    chk("rst_finish", convFinish, 0);

    for (int i = 0; i < 7; i++) run_case(vecs[i]);

    // Randomized dimensions and data.
    for (int i = 0; i < 3; i++) begin
      vec_t r;
      r.w = int'($urandom_range(5, 14));
      r.h = int'($urandom_range(5, 10));
      r.pat = 2;
      r.chk_first = 1'b0;
      r.first_exp = 0;
      r.count_exp = (r.w - 4) * (r.h - 4);
      run_case(r);
    end

    // Reset in the middle of a run, then restart from (0,0).
    fill(0);
    build_expected(32, 32);
    apply_reset(32, 32);
    start();
    for (int i = 0; i < 200 && cyc < 100; i++) @(negedge clk);
    #1;
    chk("pre_reset_busy", ramImage_en_r, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_img_en", ramImage_en_r, 0);
    chk("mid_rst_img_addr", ramImage_addrR, 0);
    chk("mid_rst_wgt_en", ramWeight_en_r, 0);
    chk("mid_rst_wgt_addr", ramWeight_addrR, 0);
    chk("mid_rst_valid", conv_valid, 0);
    chk("mid_rst_data", conv_data, 0);
    chk("mid_rst_x", conv_x, 0);
    chk("mid_rst_y", conv_y, 0);
    chk("mid_rst_finish", convFinish, 0);
    mon_en = 1'b0;
    build_expected(32, 32);
    @(negedge clk); #1;
    rst_n = 1'b1;
    reset_mon();
    mon_en = 1'b1;
    for (int i = 0; i < 29 * 30 && got < 29; i++) @(negedge clk);
    #1;
    chk("restart_strobes", got, 29);
    chk("restart_latency", first_lat, 29);
    chk("restart_first", got_data[0], 27850);
    chk("restart_1_0", got_data[1], 28150);
    chk("restart_0_1", got_data[28], 37450);
    mon_en = 1'b0;

    // convStart released during RUN of pixel (3,0): run completes, finish pulses once.
    fill(2);
    build_expected(12, 8);
    apply_reset(12, 8);
    start();
    for (int i = 0; i < 200 && got < 3; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    #1;
    chk("early_drop_in_run", ramImage_en_r, 1);
    convStart = 1'b0;
    wait_finish(32 * 29 + 60);
    chk("early_drop_strobes", got, 32);
    chk("early_drop_finish_cycle", fin_lat, 29 * 32 + 1);
    chk("early_drop_leftover", exp_d.size(), 0);
    @(negedge clk); #1;
    chk("early_drop_finish_pulse", convFinish, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("early_drop_idle", 64'(got), 64'd32);
    chk("early_drop_hold", hold_bad, 0);
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_core.md
CONV_CORE -- requirements
Module: conv_core

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: convStart  input  1  level; high = image and weight RAMs loaded, run requested.
REQ-004 SHALL have ports: W  input  6  image width (pixels); H  input  6  image height; C  input  5  channel count (informational, not used in arithmetic).
REQ-005 SHALL have ports: ramImage_en_r  output  1  image RAM read enable; ramImage_addrR  output  10  image read address; ramImage_dout  input  128  image read data, 1-cycle latency after en_r/addr.
REQ-006 SHALL have ports: ramWeight_en_r  output  1  weight RAM read enable; ramWeight_addrR  output  5  weight read address; ramWeight_dout  input  128  weight read data, 1-cycle latency.
REQ-007 SHALL have ports: conv_valid  output  1  one-cycle result strobe; conv_data  output  40  signed result; conv_x  output  6  and conv_y  output  6  output-pixel coordinates.
REQ-008 SHALL have ports: convFinish  output  1  level; high = all outputs produced, held until convStart low.

Function
REQ-009 SHALL treat each 128-bit word as 8 signed 16-bit lanes, lane i = bits [16i+15:16i].
REQ-010 SHALL compute a 5x5 valid convolution, stride 1: outputs (ox,oy), ox 0..W-5, oy 0..H-5, raster order (ox fastest).
REQ-011 SHALL form conv_data(ox,oy) = sum over ky,kx in 0..4 and lanes 0..7 of img[(oy+ky)*W+ox+kx].lane * wgt[ky*5+kx].lane, full signed precision, 40-bit result (no overflow possible).
REQ-012 SHALL latch W and H on leaving IDLE; input changes mid-run are ignored.
REQ-013 SHALL implement FSM IDLE, RUN, DRAIN, OUT, DONE.
REQ-014 IDLE: convStart high -> RUN next cycle with k=0, (ox,oy)=(0,0); if latched W<5 or H<5 -> DONE directly, no reads, no conv_valid.
REQ-015 RUN: 25 cycles, k=0..24 (kx fastest); ramImage_en_r=ramWeight_en_r=1, ramImage_addrR=(oy+ky)*W+ox+kx mod 1024, ramWeight_addrR=k.
REQ-016 Pipeline: dout arrives cycle after issue; 8-lane product sum registered one cycle later; accumulated the following cycle.
REQ-017 DRAIN: 3 cycles, RAM enables low; OUT: 1 cycle, conv_valid=1 with conv_data, conv_x=ox, conv_y=oy; accumulator cleared.
REQ-018 After OUT: if last pixel -> DONE, else advance (ox,oy) and -> RUN; period = 29 cycles per output pixel.
REQ-019 DONE: convFinish=1; on convStart low -> IDLE next cycle with convFinish=0.
REQ-020 convStart deasserting during RUN/DRAIN/OUT SHALL be ignored; run completes.
REQ-021 W*H>1024 is out of range; addresses wrap mod 1024, no error flag.
REQ-022 conv_data, conv_x, conv_y SHALL hold last values outside OUT.

Reset
REQ-023 rst_n low SHALL immediately force: FSM IDLE, all counters and accumulator 0, all outputs 0 (en_r, addrR, conv_valid, conv_data, conv_x, conv_y, convFinish).
REQ-024 Reset mid-run SHALL abandon the run; after release with convStart high, a new run starts at (0,0).

Verification
REQ-025 Image word n = n (lane 0 only), weight word k = k, W=H=32, convStart high -> first conv_valid 29 cycles after RUN entry with (0,0)=27850; (1,0)=28150; (0,1)=37450.
REQ-026 Same setup -> exactly 784 conv_valid strobes, last at (27,27), then convFinish=1 held; drop convStart -> convFinish=0 next cycle, FSM IDLE.
REQ-027 All image lanes 0xFFFF, all weight lanes 0x0002 -> every conv_data = -400 (0xFFFFFFFE70).
REQ-028 W=4, H=32, convStart high -> no RAM reads, no conv_valid, convFinish=1 one cycle after start.
REQ-029 rst_n low at cycle 100 of a run -> all outputs 0 same cycle; release with convStart high -> first result again (0,0)=27850.
REQ-030 convStart dropped during RUN of pixel (3,0) -> run continues to all 784 outputs; convFinish pulses for one cycle then IDLE.
